// File: rtl/shift_reg_seq.sv
// Command sequencer for an external universal shift register.
// Ports: CLK/Clear, command in (start/cmd_*), A_par feedback, s1/s0/MSB_in/LSB_in/I_par out, busy/done/cmd_err.
module shift_reg_seq #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [2:0]       cmd_count,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] A_par,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic [WIDTH-1:0] I_par,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_LROR = 3'd5;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_cnt;
  logic             r_err;
  logic             w_legal;
  logic             w_accept;
  logic             w_unused;

  assign w_legal  = (cmd_op <= OP_LROR);
  assign w_accept = (r_state == S_IDLE) && start && w_legal;
  // Only the end bits of A_par feed the rotate paths.
  assign w_unused = ^A_par;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && start && !w_legal;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_cnt  <= cmd_count;
      end else if (r_state == S_SHIFT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD || cmd_op == OP_LROR)
            w_next = S_LOAD;
          else if (cmd_count == 3'd0)
            w_next = S_DONE;
          else
            w_next = S_SHIFT;
        end
      end
      S_LOAD: begin
        if (r_op == OP_LROR && r_cnt != 3'd0)
          w_next = S_SHIFT;
        else
          w_next = S_DONE;
      end
      // r_cnt holds cycles remaining including this one.
      S_SHIFT: begin
        if (r_cnt <= 3'd1)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s1     = 1'b0;
    s0     = 1'b0;
    MSB_in = 1'b0;
    LSB_in = 1'b0;
    I_par  = '0;
    if (r_state == S_LOAD) begin
      s1    = 1'b1;
      s0    = 1'b1;
      I_par = r_data;
    end else if (r_state == S_SHIFT) begin
      unique case (r_op)
        OP_SHR: begin
          s0     = 1'b1;
          MSB_in = ser_in;
        end
        OP_SHL: begin
          s1     = 1'b1;
          LSB_in = ser_in;
        end
        OP_ROR, OP_LROR: begin
          s0     = 1'b1;
          MSB_in = A_par[0];
        end
        OP_ROL: begin
          s1     = 1'b1;
          LSB_in = A_par[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign cmd_err = r_err;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench: sequencer driving a 4-bit universal shift register.
// Expected values are hand-computed per command.
module tb_shift_reg_seq;

  logic       CLK = 1'b0;
  logic       Clear = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [2:0] cmd_count = 3'd0;
  logic       ser_in = 1'b0;
  logic [3:0] A = 4'd0;
  logic       s1, s0, MSB_in, LSB_in;
  logic [3:0] I_par;
  logic       busy, done, cmd_err;

  int n_chk = 0;
  int n_pass = 0;

  shift_reg_seq #(.WIDTH(4)) dut (
    .CLK(CLK), .Clear(Clear), .start(start),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .ser_in(ser_in),
    .A_par(A), .s1(s1), .s0(s0),
    .MSB_in(MSB_in), .LSB_in(LSB_in),
    .I_par(I_par), .busy(busy), .done(done),
    .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) begin
    case ({s1, s0})
      2'b01:   A <= {MSB_in, A[3:1]};
      2'b10:   A <= {A[2:0], LSB_in};
      2'b11:   A <= I_par;
      default: ;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [3:0] d,
                       input logic [2:0] n,
                       input logic si);
    start = 1'b1;
    cmd_op = op;
    cmd_data = d;
    cmd_count = n;
    ser_in = si;
    tick();
    start = 1'b0;
  endtask

  initial begin
    Clear = 1'b1;
    tick();
    tick();
    Clear = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_mode", {s1, s0}, 0);
    chk("rst_ipar", I_par, 0);

    // LOAD 1010
    issue(3'd0, 4'b1010, 3'd0, 1'b0);
    chk("ld_mode", {s1, s0}, 2'b11);
    chk("ld_ipar", I_par, 4'b1010);
    chk("ld_busy", busy, 1);
    tick();
    chk("ld_done", done, 1);
    chk("ld_A", A, 4'b1010);
    tick();
    chk("ld_idle_done", done, 0);
    chk("ld_idle_busy", busy, 0);

    // ROR 1 from 1010
    issue(3'd3, 4'd0, 3'd1, 1'b0);
    chk("ror_mode", {s1, s0}, 2'b01);
    chk("ror_msb", MSB_in, 0);
    tick();
    chk("ror_done", done, 1);
    chk("ror_A", A, 4'b0101);
    tick();

    // LOAD 0001 then ROL 3
    issue(3'd0, 4'b0001, 3'd0, 1'b0);
    tick();
    tick();
    issue(3'd4, 4'd0, 3'd3, 1'b0);
    chk("rol_mode", {s1, s0}, 2'b10);
    chk("rol_lsb", LSB_in, 0);
    tick();
    tick();
    chk("rol_c3_done", done, 0);
    tick();
    chk("rol_done", done, 1);
    chk("rol_A", A, 4'b1000);
    tick();

    // LOAD_ROR 1001 count 4, stray start in cycle 3
    issue(3'd5, 4'b1001, 3'd4, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("lr_busy_c%0d", c), busy, 1);
      chk($sformatf("lr_mode_c%0d", c), {s1, s0},
          (c == 1) ? 2'b11 : (c == 6) ? 2'b00 : 2'b01);
      chk($sformatf("lr_done_c%0d", c), done, (c == 6));
      if (c == 3) begin
        start = 1'b1;
        cmd_op = 3'd0;
        cmd_data = 4'b0000;
      end else begin
        start = 1'b0;
      end
      if (c < 6) tick();
    end
    chk("lr_A", A, 4'b1001);
    tick();
    chk("lr_idle_busy", busy, 0);

    // LOAD 0000, SHR 2 with ser_in=1
    issue(3'd0, 4'b0000, 3'd0, 1'b0);
    tick();
    tick();
    issue(3'd1, 4'd0, 3'd2, 1'b1);
    chk("shr_msb", MSB_in, 1);
    chk("shr_mode", {s1, s0}, 2'b01);
    tick();
    tick();
    chk("shr_done", done, 1);
    chk("shr_A", A, 4'b1100);
    tick();

    // SHL count 0: straight to DONE
    issue(3'd2, 4'd0, 3'd0, 1'b1);
    chk("shl0_done", done, 1);
    chk("shl0_mode", {s1, s0}, 0);
    chk("shl0_lsb", LSB_in, 0);
    tick();
    chk("shl0_A", A, 4'b1100);

    // Illegal opcode 110
    issue(3'd6, 4'b1111, 3'd3, 1'b0);
    chk("ill_err", cmd_err, 1);
    chk("ill_busy", busy, 0);
    tick();
    chk("ill_err_clr", cmd_err, 0);
    chk("ill_busy2", busy, 0);
    chk("ill_A", A, 4'b1100);

    // ROR 5 from 1100, Clear (with start) in cycle 2
    issue(3'd3, 4'd0, 3'd5, 1'b0);
    chk("clr_c1_mode", {s1, s0}, 2'b01);
    tick();
    Clear = 1'b1;
    start = 1'b1;
    cmd_op = 3'd0;
    cmd_data = 4'b1111;
    tick();
    Clear = 1'b0;
    start = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_mode", {s1, s0}, 0);
    chk("clr_done", done, 0);
    chk("clr_A", A, 4'b0011);
    tick();
    chk("clr_done2", done, 0);
    chk("clr_busy2", busy, 0);
    chk("clr_A2", A, 4'b0011);

    // LOAD_ROR count 0: LOAD then DONE
    issue(3'd5, 4'b0110, 3'd0, 1'b0);
    chk("lr0_mode", {s1, s0}, 2'b11);
    tick();
    chk("lr0_done", done, 1);
    chk("lr0_A", A, 4'b0110);
    tick();
    chk("lr0_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
